// File: rtl/dl_pend_drain_pkg.sv
// Shared helpers for the pending-event drain block.
// Holds only the index-width calculation so the top, the interface and the
// picker all size their index fields identically.
package dl_pend_drain_pkg;

  // Width of an index into NUM_BITS sources. Never 0, so a single-source
  // build still has a 1-bit index field.
  function automatic int calc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dl_pend_drain_if.sv
// Drain-side handshake of dl_pend_drain.
//   out_vld  : out_idx holds a valid event (producer -> consumer)
//   out_idx  : index of the presented event
//   out_rdy  : consumer accepts; transfer on out_vld & out_rdy
// master = event producer (dl_pend_drain), slave = consumer.
interface dl_pend_drain_if
  import dl_pend_drain_pkg::*;
#(
  parameter int NUM_BITS = 8
) ();
  localparam int IDX_W = calc_idx_w(NUM_BITS);

  logic             out_vld;
  logic [IDX_W-1:0] out_idx;
  logic             out_rdy;

  modport master (output out_vld, output out_idx, input out_rdy);
  modport slave  (input out_vld, input out_idx, output out_rdy);
endinterface

// File: rtl/dl_or.sv
// Plain W-bit OR merge, used for the set path into the pending vector.
//   i_a, i_b : operands
//   o_y      : i_a | i_b
module dl_or #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);
  assign o_y = i_a | i_b;
endmodule

// File: rtl/dl_pend_drain_rr_pick.sv
// dl_rr_pick: combinational one-of-N picker.
//   req        : request vector
//   ptr        : last granted index; rotating scan starts at ptr+1
//   rr_en      : 1 = rotating priority, 0 = lowest index wins
//   gnt_vld    : at least one request present
//   gnt_idx    : granted index
//   gnt_onehot : one-hot of the granted index (0 when none)
// Request vector is doubled so a scan starting anywhere runs linearly
// without an explicit wrap; the hit position is folded back modulo NUM_BITS.
module dl_rr_pick
  import dl_pend_drain_pkg::*;
#(
  parameter int NUM_BITS = 8,
  localparam int IDX_W   = calc_idx_w(NUM_BITS)
) (
  input  logic [NUM_BITS-1:0] req,
  input  logic [IDX_W-1:0]    ptr,
  input  logic                rr_en,
  output logic                gnt_vld,
  output logic [IDX_W-1:0]    gnt_idx,
  output logic [NUM_BITS-1:0] gnt_onehot
);
  logic [2*NUM_BITS-1:0] w_dbl;
  int                    w_start;
  int                    w_hit;

  always_comb begin
    gnt_vld    = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    w_hit      = 0;
    w_start    = 0;
    w_dbl      = {req, req};
    // With one source the rotation is meaningless; scan from 0.
    if (rr_en && NUM_BITS > 1) w_start = (int'(ptr) + 1) % NUM_BITS;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (!gnt_vld && w_dbl[w_start + i]) begin
        gnt_vld = 1'b1;
        w_hit   = (w_start + i) % NUM_BITS;
      end
    end
    if (gnt_vld) begin
      gnt_idx           = IDX_W'(w_hit);
      gnt_onehot[w_hit] = 1'b1;
    end
  end
endmodule

// File: rtl/dl_pend_drain.sv
// dl_pend_drain: sticky pending-event collector with one-at-a-time drain.
//   clk, rst_n : clock, async active-low reset
//   set_in     : event pulses, OR-merged into the pending vector
//   clr_all    : synchronous flush of pend/ovfl/output (pointer kept)
//   drn        : master handshake (out_vld, out_idx, out_rdy)
//   pend       : pending vector, excludes the event held in the output
//   ovfl       : sticky, event i arrived while i was already pending
module dl_pend_drain
  import dl_pend_drain_pkg::*;
#(
  parameter int NUM_BITS    = 8,
  parameter int ROUND_ROBIN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BITS-1:0] set_in,
  input  logic                clr_all,
  dl_pend_drain_if.master     drn,
  output logic [NUM_BITS-1:0] pend,
  output logic [NUM_BITS-1:0] ovfl
);
  localparam int IDX_W = calc_idx_w(NUM_BITS);

  logic [NUM_BITS-1:0] r_pend, r_ovfl;
  logic                r_out_vld;
  logic [IDX_W-1:0]    r_out_idx, r_ptr;

  logic                w_load, w_gnt_vld;
  logic [IDX_W-1:0]    w_gnt_idx;
  logic [NUM_BITS-1:0] w_gnt_onehot, w_drain, w_kept, w_pend_nxt;

  // Output register is free, or its content leaves this cycle.
  assign w_load  = ~r_out_vld | drn.out_rdy;
  assign w_drain = (w_load & w_gnt_vld) ? w_gnt_onehot : '0;
  assign w_kept  = r_pend & ~w_drain;

  dl_rr_pick #(.NUM_BITS(NUM_BITS)) u_pick (
    .req        (r_pend),
    .ptr        (r_ptr),
    .rr_en      (ROUND_ROBIN != 0),
    .gnt_vld    (w_gnt_vld),
    .gnt_idx    (w_gnt_idx),
    .gnt_onehot (w_gnt_onehot)
  );

  // Set is OR'd after the drain clear, so a same-cycle set re-arms the bit.
  dl_or #(.W(NUM_BITS)) u_or (
    .i_a (w_kept),
    .i_b (set_in),
    .o_y (w_pend_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend    <= '0;
      r_ovfl    <= '0;
      r_out_vld <= 1'b0;
      r_out_idx <= '0;
      r_ptr     <= '0;
    end else if (clr_all) begin
      r_pend    <= '0;
      r_ovfl    <= '0;
      r_out_vld <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      // An event matching the one in the output register is a fresh event,
      // not an overflow: that bit is no longer in r_pend.
      r_ovfl <= r_ovfl | (set_in & w_kept);
      if (w_load) begin
        r_out_vld <= w_gnt_vld;
        if (w_gnt_vld) begin
          r_out_idx <= w_gnt_idx;
          r_ptr     <= w_gnt_idx;
        end
      end
    end
  end

  assign drn.out_vld = r_out_vld;
  assign drn.out_idx = r_out_idx;
  assign pend        = r_pend;
  assign ovfl        = r_ovfl;
endmodule
